// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, instruction field positions and
// the hard-wired zero register, plus the immediate sign-extension helper.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned JADDR_W    = 26;

  // Low bit of each instruction field.
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned JADDR_LSB  = 0;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  function automatic logic [DATA_W-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
//   slave  : the decode stage view (consumes if_*, ex_ready; drives if_ready, id_*)
//   master : the surrounding pipeline view (opposite directions)
interface decode_stage_if #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W
);

  logic                              if_valid;
  logic [mips_pkg::INSTR_W-1:0]      if_instrucao;
  logic [DATA_W-1:0]                 if_pc;
  logic                              if_ready;
  logic                              ex_ready;

  logic                              id_valid;
  logic [DATA_W-1:0]                 id_pc;
  logic [mips_pkg::OPCODE_W-1:0]     id_opcode;
  logic [mips_pkg::REG_ADDR_W-1:0]   id_rs;
  logic [mips_pkg::REG_ADDR_W-1:0]   id_rt;
  logic [mips_pkg::REG_ADDR_W-1:0]   id_rd;
  logic [mips_pkg::SHAMT_W-1:0]      id_shamt;
  logic [mips_pkg::FUNCT_W-1:0]      id_funct;
  logic [DATA_W-1:0]                 id_imm_ext;
  logic [mips_pkg::JADDR_W-1:0]      id_jaddr;
  logic [DATA_W-1:0]                 id_rs_data;
  logic [DATA_W-1:0]                 id_rt_data;

  modport slave (
    input  if_valid, if_instrucao, if_pc, ex_ready,
    output if_ready, id_valid, id_pc, id_opcode, id_rs, id_rt, id_rd, id_shamt,
           id_funct, id_imm_ext, id_jaddr, id_rs_data, id_rt_data
  );

  modport master (
    output if_valid, if_instrucao, if_pc, ex_ready,
    input  if_ready, id_valid, id_pc, id_opcode, id_rs, id_rt, id_rd, id_shamt,
           id_funct, id_imm_ext, id_jaddr, id_rs_data, id_rt_data
  );

endinterface

// File: rtl/register_file.sv
// 2-read / 1-write register file with hard-wired zero register.
//   clk_fpga, reset (async, active-low clear of every register)
//   we/waddr/wdata     : synchronous write port (writes to register 0 dropped)
//   raddr_a/rdata_a,
//   raddr_b/rdata_b    : combinational read ports returning pre-write contents
module register_file #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic              clk_fpga,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: IF/ID pipeline register, register file and
// field split, with a valid/ready handshake, stall and flush.
//   clk_fpga, reset (async, active-low)
//   flush                  : drop the held and incoming instruction
//   wb_en/wb_addr/wb_data  : register file write-back port
//   bus (decode_stage_if.slave) : if_* from fetch, id_* to control/execute
// Optional feature macro: WRITE_BYPASS_EN forwards a same-edge write-back into
// the captured operands and refreshes held operands during a stall.
module decode_stage #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned NREGS  = 32
) (
  input  logic                            clk_fpga,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            wb_en,
  input  logic [mips_pkg::REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]               wb_data,
  decode_stage_if.slave                   bus
);
  import mips_pkg::*;

  logic                  valid_q, valid_d;
  logic [INSTR_W-1:0]    instr_q, instr_d;
  logic [DATA_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d;
  logic [DATA_W-1:0]     rt_data_q, rt_data_d;

  logic                  accept;
  logic [REG_ADDR_W-1:0] in_rs, in_rt;
  logic [DATA_W-1:0]     rf_rs_data, rf_rt_data;
  logic [DATA_W-1:0]     cap_rs_data, cap_rt_data;

  assign bus.if_ready = !valid_q || bus.ex_ready;
  assign accept       = bus.if_valid && bus.if_ready;

  assign in_rs = bus.if_instrucao[RS_LSB +: REG_ADDR_W];
  assign in_rt = bus.if_instrucao[RT_LSB +: REG_ADDR_W];

  register_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (REG_ADDR_W)
  ) u_register_file (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .we       (wb_en),
    .waddr    (wb_addr),
    .wdata    (wb_data),
    .raddr_a  (in_rs),
    .rdata_a  (rf_rs_data),
    .raddr_b  (in_rt),
    .rdata_b  (rf_rt_data)
  );

`ifdef WRITE_BYPASS_EN
  logic wb_live;
  logic stall;
  assign wb_live = wb_en && (wb_addr != REG_ZERO);
  assign stall   = valid_q && !bus.ex_ready;
  // A write landing on the capture edge would otherwise be lost to this instruction.
  assign cap_rs_data = (wb_live && (wb_addr == in_rs)) ? wb_data : rf_rs_data;
  assign cap_rt_data = (wb_live && (wb_addr == in_rt)) ? wb_data : rf_rt_data;
`else
  assign cap_rs_data = rf_rs_data;
  assign cap_rt_data = rf_rt_data;
`endif

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      instr_d   = bus.if_instrucao;
      pc_d      = bus.if_pc;
      rs_data_d = cap_rs_data;
      rt_data_d = cap_rt_data;
    end else if (bus.ex_ready) begin
      valid_d = 1'b0;
    end
`ifdef WRITE_BYPASS_EN
    else if (stall) begin
      if (wb_live && (wb_addr == instr_q[RS_LSB +: REG_ADDR_W])) rs_data_d = wb_data;
      if (wb_live && (wb_addr == instr_q[RT_LSB +: REG_ADDR_W])) rt_data_d = wb_data;
    end
`endif
  end

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
    end
  end

  // Fields are slices of the registered word, so they are stable all cycle.
  assign bus.id_valid   = valid_q;
  assign bus.id_pc      = pc_q;
  assign bus.id_opcode  = instr_q[OPCODE_LSB +: OPCODE_W];
  assign bus.id_rs      = instr_q[RS_LSB +: REG_ADDR_W];
  assign bus.id_rt      = instr_q[RT_LSB +: REG_ADDR_W];
  assign bus.id_rd      = instr_q[RD_LSB +: REG_ADDR_W];
  assign bus.id_shamt   = instr_q[SHAMT_LSB +: SHAMT_W];
  assign bus.id_funct   = instr_q[FUNCT_LSB +: FUNCT_W];
  assign bus.id_imm_ext = sign_ext_imm(instr_q[IMM_LSB +: IMM_W]);
  assign bus.id_jaddr   = instr_q[JADDR_LSB +: JADDR_W];
  assign bus.id_rs_data = rs_data_q;
  assign bus.id_rt_data = rt_data_q;

endmodule
